pep_ks_lbxyz_seq: RTL



---
 rtl/pep_ks_seq_pkg.sv | 38 +++
 rtl/pep_ks_tile_cnt.sv | 57 +++++
 rtl/pep_ks_lbxyz_seq.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/pep_ks_seq_pkg.sv
// Shared widths, tile-word layout and FSM encoding for the key-switch loop sequencer.
// Changing a DEF_* value here re-derives every port and struct width together.
package pep_ks_seq_pkg;

   localparam int DEF_LBX        = 3;
   localparam int DEF_LBY        = 64;
   localparam int DEF_LBZ        = 3;
   localparam int DEF_MAX_LWE_N  = 1024;
   localparam int DEF_MAX_BLWE_K = 2048;
   localparam int DEF_MAX_KS_LVL = 8;

   localparam int XW   = $clog2(DEF_MAX_LWE_N + 1);
   localparam int YW   = $clog2(DEF_MAX_BLWE_K + 1);
   localparam int ZW   = $clog2(DEF_MAX_KS_LVL + 1);
   localparam int XNBW = $clog2(DEF_LBX + 1);
   localparam int YNBW = $clog2(DEF_LBY + 1);
   localparam int ZNBW = $clog2(DEF_LBZ + 1);

   typedef struct packed {
      logic [XW-1:0]   x_pos;
      logic [YW-1:0]   y_pos;
      logic [ZW-1:0]   z_pos;
      logic [XNBW-1:0] x_nb;
      logic [YNBW-1:0] y_nb;
      logic [ZNBW-1:0] z_nb;
      logic            first_yz;
      logic            last_yz;
      logic            last;
   } ks_seq_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_FIN,
      ST_ERR
   } ks_seq_state_e;

endpackage

// File: rtl/pep_ks_tile_cnt.sv
// One tile-loop axis: a registered position advancing by LB and wrapping after the last tile.
// pos/nb/last describe the position about to be registered, so the parent can register the tile word.
module pep_ks_tile_cnt
   import pep_ks_seq_pkg::*;
#(
   parameter int LB = DEF_LBX,
   parameter int W  = XW
) (
   input  logic                       clk,
   input  logic                       s_rst_n,
   input  logic                       clr,
   input  logic                       inc,
   input  logic [W-1:0]               limit,
   output logic [W-1:0]               pos,
   output logic [$clog2(LB+1)-1:0]    nb,
   output logic                       last
);

   localparam int         NBW    = $clog2(LB + 1);
   localparam logic [W:0] LB_EXT = (W + 1)'(LB);

   logic [W-1:0] pos_q;
   logic [W-1:0] pos_d;
   logic [W:0]   curSum;
   logic [W:0]   nxtSum;
   logic [W:0]   remain;
   logic         curLast;

   assign curSum  = {1'b0, pos_q} + LB_EXT;
   assign curLast = (curSum >= {1'b0, limit});

   // Stepping off the last tile returns to 0, which the parent reads as this axis wrapping.
   always_comb begin
      pos_d = pos_q;
      if (clr) begin
         pos_d = '0;
      end else if (inc) begin
         pos_d = curLast ? '0 : curSum[W-1:0];
      end
   end

   always_ff @(posedge clk) begin
      if (!s_rst_n) begin
         pos_q <= '0;
      end else begin
         pos_q <= pos_d;
      end
   end

   assign nxtSum = {1'b0, pos_d} + LB_EXT;
   assign remain = {1'b0, limit} - {1'b0, pos_d};

   assign pos  = pos_d;
   assign last = (nxtSum >= {1'b0, limit});
   assign nb   = (remain >= LB_EXT) ? NBW'(LB) : remain[NBW-1:0];

endmodule

// File: rtl/pep_ks_lbxyz_seq.sv
// Key-switch loop sequencer: walks x (outer), y, z (inner) tiles of a command and
// streams one registered control word per tile; FSM, command latch and output register.
module pep_ks_lbxyz_seq
   import pep_ks_seq_pkg::*;
#(
   parameter int LBX        = DEF_LBX,
   parameter int LBY        = DEF_LBY,
   parameter int LBZ        = DEF_LBZ,
   parameter int MAX_LWE_N  = DEF_MAX_LWE_N,
   parameter int MAX_BLWE_K = DEF_MAX_BLWE_K,
   parameter int MAX_KS_LVL = DEF_MAX_KS_LVL
) (
   input  logic            clk,
   input  logic            s_rst_n,
   input  logic            cmd_vld,
   output logic            cmd_rdy,
   input  logic [XW-1:0]   cmd_lwe_n,
   input  logic [YW-1:0]   cmd_blwe_k,
   input  logic [ZW-1:0]   cmd_ks_lvl,
   output logic            seq_vld,
   input  logic            seq_rdy,
   output logic [XW-1:0]   seq_x_pos,
   output logic [YW-1:0]   seq_y_pos,
   output logic [ZW-1:0]   seq_z_pos,
   output logic [XNBW-1:0] seq_x_nb,
   output logic [YNBW-1:0] seq_y_nb,
   output logic [ZNBW-1:0] seq_z_nb,
   output logic            seq_first_yz,
   output logic            seq_last_yz,
   output logic            seq_last,
   output logic            done,
   output logic            err_zero
);

   ks_seq_state_e state_q;
   ks_seq_state_e state_d;

   logic [XW-1:0] lweN_q;
   logic [YW-1:0] blweK_q;
   logic [ZW-1:0] ksLvl_q;
   logic [XW-1:0] limX;
   logic [YW-1:0] limY;
   logic [ZW-1:0] limZ;

   ks_seq_t seqWord_q;
   ks_seq_t seqWord_d;
   ks_seq_t tileNext;

   logic seqVld_q;
   logic cmdRdy_q;
   logic done_q;
   logic errZero_q;

   logic accept;
   logic step;
   logic zeroDim;
   logic incY;
   logic incX;

   logic [XW-1:0]   xPos;
   logic [YW-1:0]   yPos;
   logic [ZW-1:0]   zPos;
   logic [XNBW-1:0] xNb;
   logic [YNBW-1:0] yNb;
   logic [ZNBW-1:0] zNb;
   logic            xLast;
   logic            yLast;
   logic            zLast;

   assign accept  = cmdRdy_q & cmd_vld;
   assign step    = seqVld_q & seq_rdy;
   assign zeroDim = (cmd_lwe_n == '0) || (cmd_blwe_k == '0) || (cmd_ks_lvl == '0);

   // On the accept cycle the counters must already see the new limits to build tile 0.
   assign limX = accept ? cmd_lwe_n  : lweN_q;
   assign limY = accept ? cmd_blwe_k : blweK_q;
   assign limZ = accept ? cmd_ks_lvl : ksLvl_q;

   always_ff @(posedge clk) begin
      if (!s_rst_n) begin
         lweN_q  <= '0;
         blweK_q <= '0;
         ksLvl_q <= '0;
      end else if (accept) begin
         lweN_q  <= cmd_lwe_n;
         blweK_q <= cmd_blwe_k;
         ksLvl_q <= cmd_ks_lvl;
      end
   end

   // An outer axis advances only when every inner axis has just wrapped to 0.
   assign incY = step & (zPos == '0);
   assign incX = incY & (yPos == '0);

   pep_ks_tile_cnt #(
      .LB (LBZ),
      .W  (ZW)
   ) u_cnt_z (
      .clk     (clk),
      .s_rst_n (s_rst_n),
      .clr     (accept),
      .inc     (step),
      .limit   (limZ),
      .pos     (zPos),
      .nb      (zNb),
      .last    (zLast)
   );

   pep_ks_tile_cnt #(
      .LB (LBY),
      .W  (YW)
   ) u_cnt_y (
      .clk     (clk),
      .s_rst_n (s_rst_n),
      .clr     (accept),
      .inc     (incY),
      .limit   (limY),
      .pos     (yPos),
      .nb      (yNb),
      .last    (yLast)
   );

   pep_ks_tile_cnt #(
      .LB (LBX),
      .W  (XW)
   ) u_cnt_x (
      .clk     (clk),
      .s_rst_n (s_rst_n),
      .clr     (accept),
      .inc     (incX),
      .limit   (limX),
      .pos     (xPos),
      .nb      (xNb),
      .last    (xLast)
   );

   always_comb begin
      tileNext          = '0;
      tileNext.x_pos    = xPos;
      tileNext.y_pos    = yPos;
      tileNext.z_pos    = zPos;
      tileNext.x_nb     = xNb;
      tileNext.y_nb     = yNb;
      tileNext.z_nb     = zNb;
      tileNext.first_yz = (yPos == '0) && (zPos == '0);
      tileNext.last_yz  = yLast & zLast;
      tileNext.last     = xLast & yLast & zLast;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE: begin
            if (accept) begin
               state_d = zeroDim ? ST_ERR : ST_RUN;
            end
         end
         ST_RUN: begin
            if (step && seqWord_q.last) begin
               state_d = ST_FIN;
            end
         end
         ST_FIN:  state_d = ST_IDLE;
         ST_ERR:  state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // The word only changes on a handshake or a new command, so it holds through stalls.
   always_comb begin
      seqWord_d = seqWord_q;
      if (state_d != ST_RUN) begin
         seqWord_d = '0;
      end else if (accept || step) begin
         seqWord_d = tileNext;
      end
   end

   always_ff @(posedge clk) begin
      if (!s_rst_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge clk) begin
      if (!s_rst_n) begin
         seqWord_q <= '0;
         seqVld_q  <= 1'b0;
         cmdRdy_q  <= 1'b0;
         done_q    <= 1'b0;
         errZero_q <= 1'b0;
      end else begin
         seqWord_q <= seqWord_d;
         seqVld_q  <= (state_d == ST_RUN);
         cmdRdy_q  <= (state_d == ST_IDLE);
         done_q    <= (state_d == ST_FIN);
         errZero_q <= (state_d == ST_ERR);
      end
   end

   assign cmd_rdy      = cmdRdy_q;
   assign seq_vld      = seqVld_q;
   assign seq_x_pos    = seqWord_q.x_pos;
   assign seq_y_pos    = seqWord_q.y_pos;
   assign seq_z_pos    = seqWord_q.z_pos;
   assign seq_x_nb     = seqWord_q.x_nb;
   assign seq_y_nb     = seqWord_q.y_nb;
   assign seq_z_nb     = seqWord_q.z_nb;
   assign seq_first_yz = seqWord_q.first_yz;
   assign seq_last_yz  = seqWord_q.last_yz;
   assign seq_last     = seqWord_q.last;
   assign done         = done_q;
   assign err_zero     = errZero_q;

   // Dimensions above the configured maxima have no defined hardware behaviour.
   assert property (@(posedge clk) disable iff (!s_rst_n)
      accept |-> ((cmd_lwe_n <= XW'(MAX_LWE_N)) &&
                  (cmd_blwe_k <= YW'(MAX_BLWE_K)) &&
                  (cmd_ks_lvl <= ZW'(MAX_KS_LVL))));

endmodule
